// File: rtl/cam_pkg.sv
// cam_pkg
// Shared definitions for the camera capture path:
//   - capture FSM state encoding
//   - default frame geometry (160x120)
//   - RGB565 -> RGB111 bit positions and the packing helper
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_VS,
        ST_FRAME,
        ST_DONE
    } cap_state_t;

    localparam int DEF_H_PIX   = 160;
    localparam int DEF_V_LINES = 120;

    // RGB565 arrives as two bytes: b1 = RRRRRGGG, b2 = GGGBBBBB.
    // Only the MSB of each colour is kept.
    localparam int R_BIT = 7;   // R[4] in b1
    localparam int G_BIT = 2;   // G[5] in b1
    localparam int B_BIT = 4;   // B[4] in b2

    function automatic logic [2:0] pack_rgb111(input logic [7:0] b1, input logic [7:0] b2);
        return {b1[R_BIT], b1[G_BIT], b2[B_BIT]};
    endfunction

endpackage

// File: rtl/cam_edge_det.sv
// cam_edge_det
// Registers one camera framing input and reports its registered level plus
// single-cycle rise/fall pulses relative to the previous registered sample.
// Ports:
//   clk, rst   pixel clock, asynchronous active-high reset
//   din        raw input from the camera pin
//   level      registered copy of din
//   rise/fall  one-cycle pulses on a 0->1 / 1->0 change of the registered level
module cam_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sample_q, sample_d;
    logic prev_q,   prev_d;

    always_comb begin
        sample_d = din;
        prev_d   = sample_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sample_q <= sample_d;
            prev_q   <= prev_d;
        end
    end

    assign level = sample_q;
    assign rise  = sample_q & ~prev_q;
    assign fall  = ~sample_q & prev_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
// Turns the camera byte stream (VSYNC/HREF framing, RGB565 bytes) into
// RGB111 writes on the frame buffer write port. Snapshot or continuous capture.
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   vsync, href         camera framing (vsync high = vertical blanking)
//   px_data             camera byte, meaningful while href=1
//   mode_cont           1 = continuous capture, 0 = snapshot
//   snap_req            one-cycle request for a single frame (honoured in IDLE only)
//   addr_in/data_in     buffer write address / {R,G,B} data
//   regwrite            buffer write strobe, one cycle per pixel
//   busy                capture in progress (ARM, WAIT_VS, FRAME)
//   frame_done          one-cycle pulse at the end of a captured frame
//   frame_err           sticky geometry error, cleared when a new capture starts
module frame_capture_ctrl
    import cam_pkg::*;
#(
    parameter int AW      = 15,
    parameter int DW      = 3,
    parameter int H_PIX   = DEF_H_PIX,
    parameter int V_LINES = DEF_V_LINES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    input  logic          mode_cont,
    input  logic          snap_req,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_err
);

    // Column/line counters are wide enough to reach one past the nominal
    // size, so over-long lines and frames stay distinguishable from exact ones.
    localparam int CW = $clog2(H_PIX + 2);
    localparam int LW = $clog2(V_LINES + 2);
    localparam logic [CW-1:0] H_PIX_C   = CW'(H_PIX);
    localparam logic [LW-1:0] V_LINES_C = LW'(V_LINES);
    localparam logic [AW-1:0] H_STEP    = AW'(H_PIX);

    logic vsync_lvl, vsync_rise, vsync_fall;
    logic href_lvl, href_fall, href_rise_unused;

    cam_edge_det u_vsync_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (vsync),
        .level (vsync_lvl),
        .rise  (vsync_rise),
        .fall  (vsync_fall)
    );

    cam_edge_det u_href_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (href),
        .level (href_lvl),
        .rise  (href_rise_unused),
        .fall  (href_fall)
    );

    cap_state_t     state_q, state_d;
    logic           phase_q, phase_d;
    logic [7:0]     px_q, px_d;
    logic [7:0]     b1_q, b1_d;
    logic [CW-1:0]  col_q, col_d;
    logic [LW-1:0]  line_q, line_d;
    logic [AW-1:0]  line_base_q, line_base_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;
    logic           regwrite_q, regwrite_d;
    logic           busy_q, busy_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_err_q, frame_err_d;

    // Next-state, counter and output logic. px_data is delayed one cycle so
    // it lines up with the registered href level.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        px_d         = px_data;
        b1_d         = b1_q;
        col_d        = col_q;
        line_d       = line_q;
        line_base_d  = line_base_q;
        addr_d       = addr_q;
        data_d       = data_q;
        regwrite_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;

        case (state_q)
            ST_IDLE: begin
                phase_d     = 1'b0;
                col_d       = '0;
                line_d      = '0;
                line_base_d = '0;
                if (snap_req || mode_cont) begin
                    state_d     = ST_ARM;
                    frame_err_d = 1'b0;
                end
            end

            // Waiting for blanking first means a request issued mid-frame
            // never captures the tail of that frame.
            ST_ARM: begin
                if (vsync_lvl) begin
                    state_d = ST_WAIT_VS;
                end
            end

            ST_WAIT_VS: begin
                phase_d     = 1'b0;
                col_d       = '0;
                line_d      = '0;
                line_base_d = '0;
                if (vsync_fall) begin
                    state_d = ST_FRAME;
                end
            end

            ST_FRAME: begin
                if (href_lvl) begin
                    if (!phase_q) begin
                        b1_d    = px_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if ((col_q < H_PIX_C) && (line_q < V_LINES_C)) begin
                            regwrite_d = 1'b1;
                            addr_d     = line_base_q + AW'(col_q);
                            data_d     = DW'(pack_rgb111(b1_q, px_q));
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        if (col_q <= H_PIX_C) begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end else if (href_fall) begin
                    // A dangling odd byte is simply dropped by resetting phase.
                    phase_d = 1'b0;
                    if (col_q != '0) begin
                        if (col_q != H_PIX_C) begin
                            frame_err_d = 1'b1;
                        end
                        col_d = '0;
                        if (line_q <= V_LINES_C) begin
                            line_d = line_q + LW'(1);
                        end
                        if (line_q < V_LINES_C) begin
                            line_base_d = line_base_q + H_STEP;
                        end
                    end
                end

                if (vsync_rise) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                    if (line_d != V_LINES_C) begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                phase_d     = 1'b0;
                col_d       = '0;
                line_d      = '0;
                line_base_d = '0;
                state_d     = mode_cont ? ST_WAIT_VS : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Derived from the next state so busy falls together with frame_done.
        busy_d = (state_d == ST_ARM) || (state_d == ST_WAIT_VS) || (state_d == ST_FRAME);
    end

    // State and output registers; reset aborts any capture in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            px_q         <= '0;
            b1_q         <= '0;
            col_q        <= '0;
            line_q       <= '0;
            line_base_q  <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            regwrite_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            px_q         <= px_d;
            b1_q         <= b1_d;
            col_q        <= col_d;
            line_q       <= line_d;
            line_base_q  <= line_base_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            regwrite_q   <= regwrite_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign addr_in    = addr_q;
    assign data_in    = data_q;
    assign regwrite   = regwrite_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl
// Drives framed camera bytes into frame_capture_ctrl (4x2 geometry) and checks
// the buffer write stream and status outputs against a frame-level model.
module tb_frame_capture_ctrl;

    localparam int AW_T = 15;
    localparam int DW_T = 3;
    localparam int H_T  = 4;
    localparam int V_T  = 2;

    logic            clk;
    logic            rst;
    logic            vsync;
    logic            href;
    logic [7:0]      px_data;
    logic            mode_cont;
    logic            snap_req;
    logic [AW_T-1:0] addr_in;
    logic [DW_T-1:0] data_in;
    logic            regwrite;
    logic            busy;
    logic            frame_done;
    logic            frame_err;

    frame_capture_ctrl #(
        .AW      (AW_T),
        .DW      (DW_T),
        .H_PIX   (H_T),
        .V_LINES (V_T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .href       (href),
        .px_data    (px_data),
        .mode_cont  (mode_cont),
        .snap_req   (snap_req),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .regwrite   (regwrite),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model expectations and observed write stream
    logic [AW_T-1:0] exp_addr[$];
    logic [DW_T-1:0] exp_data[$];
    logic [AW_T-1:0] got_addr[$];
    logic [DW_T-1:0] got_data[$];
    int  done_cnt;
    int  max_addr;
    bit  spacing_viol;
    bit  overlap_viol;
    bit  prev_rw;

    logic [7:0] pat [6] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};

    // Observer: records every buffer write and frame_done pulse
    always @(negedge clk) begin
        if (regwrite) begin
            got_addr.push_back(addr_in);
            got_data.push_back(data_in);
            if (int'(addr_in) > max_addr) max_addr = int'(addr_in);
            if (prev_rw) spacing_viol = 1'b1;
        end
        prev_rw = regwrite;
        if (frame_done) begin
            done_cnt++;
            if (busy) overlap_viol = 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_obs();
        exp_addr.delete();
        exp_data.delete();
        got_addr.delete();
        got_data.delete();
        done_cnt     = 0;
        max_addr     = 0;
        spacing_viol = 1'b0;
        overlap_viol = 1'b0;
    endtask

    task automatic blank(input int n);
        vsync = 1'b1;
        href  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic active_start();
        vsync = 1'b0;
        href  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_snap();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    // One line of npix pixels; when cap is set, the model records the writes
    // the buffer should receive (only inside the 4x2 window).
    task automatic drive_line(input int npix, input bit cap, input int lidx, input bit use_pat);
        logic [7:0] b1, b2;
        for (int j = 0; j < npix; j++) begin
            if (use_pat && j < 3) begin
                b1 = pat[2*j];
                b2 = pat[2*j+1];
            end else begin
                b1 = 8'($urandom);
                b2 = 8'($urandom);
            end
            if (cap && lidx < V_T && j < H_T) begin
                exp_addr.push_back(AW_T'(lidx * H_T + j));
                exp_data.push_back({b1[7], b1[2], b2[4]});
            end
            href = 1'b1; px_data = b1; tick();
            px_data = b2; tick();
        end
        href = 1'b0;
        repeat (3) begin
            px_data = 8'($urandom);
            tick();
        end
    endtask

    task automatic drive_frame(input int nlines, input int ppl[8], input bit cap, output bit exp_err);
        exp_err = (nlines != V_T);
        active_start();
        for (int l = 0; l < nlines; l++) begin
            if (ppl[l] != H_T) exp_err = 1'b1;
            drive_line(ppl[l], cap, l, 1'b0);
        end
        blank(6);
    endtask

    function automatic int first_write_diff();
        int n;
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) return i;
        end
        if (got_addr.size() != exp_addr.size()) return n;
        return -1;
    endfunction

    function automatic string diff_str(input int idx);
        string s;
        s = $sformatf("count %0d required %0d", got_addr.size(), exp_addr.size());
        if (idx < got_addr.size() && idx < exp_addr.size())
            s = {s, $sformatf(", write #%0d addr/data %0d/%b required %0d/%b",
                 idx, got_addr[idx], got_data[idx], exp_addr[idx], exp_data[idx])};
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b0; href = 1'b0; px_data = 8'h00;
        mode_cont = 1'b0; snap_req = 1'b0;
        #2;
        n_cmp++;
        if ({addr_in, data_in} !== '0) begin
            n_fail++; $display("[TB] FAIL reset_addr_data: got %h/%b required 0/0", addr_in, data_in);
        end
        n_cmp++;
        if ({regwrite, busy, frame_done, frame_err} !== 4'b0) begin
            n_fail++; $display("[TB] FAIL reset_flags: got %b required 0000", {regwrite, busy, frame_done, frame_err});
        end
        repeat (2) tick();
        rst = 1'b0;
        blank(3);
    endtask

    task automatic test_snapshot();
        int  idx;
        clear_obs();
        blank(2);
        pulse_snap();
        blank(3);
        active_start();
        drive_line(4, 1'b1, 0, 1'b1);
        drive_line(4, 1'b1, 1, 1'b0);
        vsync = 1'b1;
        tick();
        n_cmp++;
        if (frame_done !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL snap_done_early: done/busy %b%b required 01", frame_done, busy);
        end
        tick();
        n_cmp++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL snap_done_timing: done/busy %b%b required 10", frame_done, busy);
        end
        tick();
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL snap_done_width: done %b required 0", frame_done);
        end
        blank(4);
        idx = first_write_diff();
        n_cmp++;
        if (idx >= 0) begin
            n_fail++; $display("[TB] FAIL snap_writes: %s", diff_str(idx));
        end
        if (got_data.size() >= 3) begin
            n_cmp++;
            if ({got_data[0], got_data[1], got_data[2]} !== 9'b100_010_001) begin
                n_fail++; $display("[TB] FAIL snap_colours: got %b %b %b required 100 010 001",
                                   got_data[0], got_data[1], got_data[2]);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL snap_status: done=%0d err=%b busy=%b required 1/0/0", done_cnt, frame_err, busy);
        end
        n_cmp++;
        if (spacing_viol || overlap_viol) begin
            n_fail++; $display("[TB] FAIL snap_strobe_rules: spacing=%b done_with_busy=%b required 0/0", spacing_viol, overlap_viol);
        end
    endtask

    task automatic test_midframe_snap();
        int ppl[8] = '{4, 4, 0, 0, 0, 0, 0, 0};
        bit e_err;
        int idx;
        clear_obs();
        active_start();
        drive_line(4, 1'b0, 0, 1'b0);
        pulse_snap();
        drive_line(4, 1'b0, 1, 1'b0);
        blank(6);
        n_cmp++;
        if (got_addr.size() != 0 || done_cnt != 0 || busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midsnap_partial: writes=%0d done=%0d busy=%b required 0/0/1",
                               got_addr.size(), done_cnt, busy);
        end
        drive_frame(2, ppl, 1'b1, e_err);
        idx = first_write_diff();
        n_cmp++;
        if (idx >= 0) begin
            n_fail++; $display("[TB] FAIL midsnap_writes: %s", diff_str(idx));
        end
        n_cmp++;
        if (done_cnt != 1 || frame_err !== e_err) begin
            n_fail++; $display("[TB] FAIL midsnap_status: done=%0d err=%b required 1/%b", done_cnt, frame_err, e_err);
        end
    endtask

    task automatic test_clip();
        int ppl[8] = '{3, 6, 0, 0, 0, 0, 0, 0};
        bit e_err;
        int idx;
        clear_obs();
        pulse_snap();
        blank(3);
        drive_frame(2, ppl, 1'b1, e_err);
        idx = first_write_diff();
        n_cmp++;
        if (idx >= 0) begin
            n_fail++; $display("[TB] FAIL clip_writes: %s", diff_str(idx));
        end
        n_cmp++;
        if (max_addr > H_T * V_T - 1) begin
            n_fail++; $display("[TB] FAIL clip_max_addr: got %0d required <= %0d", max_addr, H_T * V_T - 1);
        end
        n_cmp++;
        if (frame_err !== 1'b1 || done_cnt != 1) begin
            n_fail++; $display("[TB] FAIL clip_status: err=%b done=%0d required 1/1", frame_err, done_cnt);
        end
        pulse_snap();
        tick();
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL clip_err_clear: err=%b required 0", frame_err);
        end
        blank(3);
        mode_cont = 1'b0;
        drive_frame(2, '{4, 4, 0, 0, 0, 0, 0, 0}, 1'b0, e_err);
    endtask

    task automatic test_continuous();
        int idx;
        clear_obs();
        mode_cont = 1'b1;
        blank(4);
        for (int f = 0; f < 3; f++) begin
            active_start();
            for (int l = 0; l < V_T; l++) begin
                if (f == 2 && l == 1) mode_cont = 1'b0;
                drive_line(H_T, 1'b1, l, 1'b0);
            end
            blank(6);
        end
        idx = first_write_diff();
        n_cmp++;
        if (idx >= 0) begin
            n_fail++; $display("[TB] FAIL cont_writes: %s", diff_str(idx));
        end
        if (got_addr.size() == 24) begin
            n_cmp++;
            if (got_addr[8] !== '0 || got_addr[16] !== '0) begin
                n_fail++; $display("[TB] FAIL cont_addr_restart: got %0d %0d required 0 0", got_addr[8], got_addr[16]);
            end
        end
        n_cmp++;
        if (done_cnt != 3 || busy !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL cont_status: done=%0d busy=%b err=%b required 3/0/0", done_cnt, busy, frame_err);
        end
    endtask

    task automatic test_reset_midframe();
        int ppl[8] = '{4, 4, 0, 0, 0, 0, 0, 0};
        bit e_err;
        int idx;
        clear_obs();
        pulse_snap();
        blank(3);
        active_start();
        drive_line(4, 1'b1, 0, 1'b0);
        drive_line(1, 1'b1, 1, 1'b0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({addr_in, data_in, regwrite, busy, frame_done, frame_err} !== '0) begin
            n_fail++; $display("[TB] FAIL rst_mid_outputs: got addr=%0d data=%b flags=%b required all 0",
                               addr_in, data_in, {regwrite, busy, frame_done, frame_err});
        end
        tick();
        rst = 1'b0;
        drive_line(4, 1'b0, 1, 1'b0);
        blank(6);
        idx = first_write_diff();
        n_cmp++;
        if (idx >= 0 || done_cnt != 0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rst_mid_quiet: %s, done=%0d busy=%b required done 0 busy 0",
                               diff_str(idx), done_cnt, busy);
        end
        pulse_snap();
        blank(3);
        drive_frame(2, ppl, 1'b1, e_err);
        idx = first_write_diff();
        n_cmp++;
        if (idx >= 0) begin
            n_fail++; $display("[TB] FAIL rst_recapture_writes: %s", diff_str(idx));
        end
        n_cmp++;
        if (done_cnt != 1 || frame_err !== e_err) begin
            n_fail++; $display("[TB] FAIL rst_recapture_status: done=%0d err=%b required 1/%b", done_cnt, frame_err, e_err);
        end
    endtask

    task automatic test_random_frames();
        int ppl[8];
        int nlines;
        bit e_err;
        int idx;
        for (int it = 0; it < 8; it++) begin
            clear_obs();
            nlines = $urandom_range(V_T + 1, V_T - 1);
            for (int l = 0; l < 8; l++) ppl[l] = $urandom_range(H_T + 1, H_T - 1);
            pulse_snap();
            blank(3);
            drive_frame(nlines, ppl, 1'b1, e_err);
            idx = first_write_diff();
            n_cmp++;
            if (idx >= 0) begin
                n_fail++; $display("[TB] FAIL rand%0d_writes: %s", it, diff_str(idx));
            end
            n_cmp++;
            if (frame_err !== e_err || done_cnt != 1 || max_addr > H_T * V_T - 1) begin
                n_fail++; $display("[TB] FAIL rand%0d_status: err=%b done=%0d max=%0d required %b/1/<=%0d",
                                   it, frame_err, done_cnt, max_addr, e_err, H_T * V_T - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_midframe_snap();
        test_clip();
        test_continuous();
        test_reset_midframe();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
